// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS-I subset core with req/ack instruction and data ports
//
// Purpose: runs addi/add/sub/and/or/slt/lw/sw/beq/j/syscall through a
// FETCH/DECODE/EXEC/MEM/WB state machine. The register file and the
// retired-instruction counter are internal.
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   inst_req, inst_addr            registered fetch request and fetch address (PC)
//   inst_ack, inst                 fetch completion and instruction word (same cycle)
//   mem_req, mem_we, mem_addr,     registered data request, store select, word address,
//   mem_wdata                      and store data
//   mem_ack, mem_rdata             data completion and load data (same cycle)
//   halted, fault                  sticky stop flag and stop cause (illegal/misaligned)
//   retired                        completed-instruction count, wraps at 2^CNT_W
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_ack,
  input  logic [31:0]      inst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc, ir, a_reg, b_reg, imm_reg, pc4_reg, target_reg, alu_out, mdr;
  logic [31:0] rf [NUM_REGS];

  // Instruction fields
  logic [5:0]    op, funct;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [31:0]   imm_sx, pc4_dec, rd_a, rd_b, alu_result, jump_target, wb_data;
  logic          is_alu_r, is_syscall, is_legal, is_mem_op, misaligned, inst_done, mem_done;

  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  // Register indices keep only the low bits when the file is smaller than 32
  assign rs_idx = ir[21 +: RW];
  assign rt_idx = ir[16 +: RW];
  assign rd_idx = ir[11 +: RW];

  assign imm_sx  = {{16{ir[15]}}, ir[15:0]};
  assign pc4_dec = pc + 32'd4;
  assign rd_a    = (rs_idx == '0) ? 32'h0 : rf[rs_idx];
  assign rd_b    = (rt_idx == '0) ? 32'h0 : rf[rt_idx];

  assign is_alu_r   = (op == OP_RTYPE) &&
                      (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                       funct == FN_OR  || funct == FN_SLT);
  assign is_syscall = (op == OP_RTYPE) && (funct == FN_SYSCALL);
  assign is_legal   = is_alu_r || is_syscall || op == OP_J || op == OP_BEQ ||
                      op == OP_ADDI || op == OP_LW || op == OP_SW;
  assign is_mem_op  = (op == OP_LW) || (op == OP_SW);
  assign misaligned = (alu_result[1:0] != 2'b00);

  assign jump_target = {pc4_reg[31:28], ir[25:0], 2'b00};
  assign wb_idx      = (op == OP_RTYPE) ? rd_idx : rt_idx;
  assign wb_data     = (op == OP_LW) ? mdr : alu_out;

  // Acks only count while the matching request is actually up
  assign inst_done = inst_req && inst_ack;
  assign mem_done  = mem_req && mem_ack;

  assign inst_addr = pc;

  always_comb begin
    alu_result = 32'h0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_result = a_reg + b_reg;
          FN_SUB:  alu_result = a_reg - b_reg;
          FN_AND:  alu_result = a_reg & b_reg;
          FN_OR:   alu_result = a_reg | b_reg;
          FN_SLT:  alu_result = {31'h0, $signed(a_reg) < $signed(b_reg)};
          default: alu_result = 32'h0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_result = a_reg + imm_reg;
      default:               alu_result = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (inst_done) state_nx = S_DECODE;
      S_DECODE: begin
        if (!is_legal || is_syscall) state_nx = S_HALT;
        else                         state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem_op)                         state_nx = misaligned ? S_HALT : S_MEM;
        else if (op == OP_BEQ || op == OP_J)   state_nx = S_FETCH;
        else                                   state_nx = S_WB;
      end
      S_MEM:    if (mem_done) state_nx = (op == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_HALT;
    endcase
  end

  // Output logic: next PC, retire strobe and fault cause
  logic [31:0] pc_nx;
  logic        retire_en, fault_nx;

  always_comb begin
    pc_nx     = pc;
    retire_en = 1'b0;
    fault_nx  = fault;
    case (state)
      S_DECODE: if (!is_legal) fault_nx = 1'b1;
      S_EXEC: begin
        if (is_mem_op && misaligned) fault_nx = 1'b1;
        if (op == OP_BEQ) begin
          pc_nx     = (a_reg == b_reg) ? target_reg : pc4_reg;
          retire_en = 1'b1;
        end else if (op == OP_J) begin
          pc_nx     = jump_target;
          retire_en = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_done && op == OP_SW) begin
          pc_nx     = pc4_reg;
          retire_en = 1'b1;
        end
      end
      S_WB: begin
        pc_nx     = pc4_reg;
        retire_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs. Requests are derived from the next state
  // so they rise on the edge that enters FETCH/MEM and drop on the edge that
  // consumes the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= 32'h0;
      a_reg      <= 32'h0;
      b_reg      <= 32'h0;
      imm_reg    <= 32'h0;
      pc4_reg    <= 32'h0;
      target_reg <= 32'h0;
      alu_out    <= 32'h0;
      mdr        <= 32'h0;
      inst_req   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      retired    <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'h0;
    end else begin
      inst_req <= (state_nx == S_FETCH);
      mem_req  <= (state_nx == S_MEM);
      mem_we   <= (state_nx == S_MEM) && (op == OP_SW);
      halted   <= (state_nx == S_HALT);
      fault    <= fault_nx;
      pc       <= pc_nx;
      if (retire_en) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};

      if (state == S_FETCH && inst_done) ir <= inst;

      if (state == S_DECODE) begin
        a_reg      <= rd_a;
        b_reg      <= rd_b;
        imm_reg    <= imm_sx;
        pc4_reg    <= pc4_dec;
        target_reg <= pc4_dec + {imm_sx[29:0], 2'b00};
      end

      if (state == S_EXEC) begin
        alu_out <= alu_result;
        if (state_nx == S_MEM) begin
          mem_addr  <= alu_result;
          mem_wdata <= b_reg;
        end
      end

      if (state == S_MEM && mem_done) mdr <= mem_rdata;

      if (state == S_WB && wb_idx != '0) rf[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, inst_ack;
  logic [31:0] inst_addr, inst;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted, fault;
  logic [31:0] retired;

  mips_multicycle_core dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst(inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  int          i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
  bit          force_dack = 0, mem_req_seen = 0;

  int          fetch_addr[$];
  int          fetch_cyc[$];
  int          acc_addr[$], acc_we[$], acc_wd[$], acc_len[$], acc_stable[$];
  logic [31:0] cur_addr, cur_wd;
  logic        cur_we, cur_stable;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory responder with i_wait wait cycles before each ack
  initial begin
    inst_ack = 1'b0;
    inst     = 32'h0;
    forever begin
      @(negedge clk);
      if (inst_req) begin
        if (i_cnt >= i_wait) begin
          inst_ack = 1'b1;
          inst     = imem[inst_addr[8:2]];
          fetch_addr.push_back(int'(inst_addr));
          fetch_cyc.push_back(cyc);
          i_cnt    = 0;
        end else begin
          inst_ack = 1'b0;
          i_cnt++;
        end
      end else begin
        inst_ack = 1'b0;
        i_cnt    = 0;
      end
    end
  end

  // Data memory responder: logs each access, its request length and stability
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) mem_req_seen = 1'b1;
      if (force_dack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        d_cnt     = 0;
      end else if (mem_req) begin
        if (d_cnt == 0) begin
          cur_addr = mem_addr; cur_we = mem_we; cur_wd = mem_wdata; cur_stable = 1'b1;
        end else if (mem_addr !== cur_addr || mem_we !== cur_we || mem_wdata !== cur_wd) begin
          cur_stable = 1'b0;
        end
        d_cnt++;
        if (d_cnt > d_wait) begin
          mem_ack = 1'b1;
          if (cur_we) dmem[mem_addr[7:2]] = mem_wdata;
          else        mem_rdata = dmem[mem_addr[7:2]];
          acc_addr.push_back(int'(mem_addr));
          acc_we.push_back(int'(mem_we));
          acc_wd.push_back(int'(mem_wdata));
          acc_len.push_back(d_cnt);
          acc_stable.push_back(int'(cur_stable));
          d_cnt = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        d_cnt   = 0;
      end
    end
  end

  task automatic clear_logs();
    fetch_addr.delete(); fetch_cyc.delete();
    acc_addr.delete(); acc_we.delete(); acc_wd.delete(); acc_len.delete(); acc_stable.delete();
    mem_req_seen = 1'b0;
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++)  dmem[i] = 32'h0;
    i_wait = 0; d_wait = 0; force_dack = 1'b0;
    clear_logs();
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    // ---------------- Reset values and first fetch ----------------
    start_reset();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_ADDI, 0, 2, 16'hFFFD);
    imem[2] = enc_r(1, 2, 3, 6'h20);
    imem[3] = enc_r(2, 1, 4, 6'h2A);
    imem[4] = enc_r(0, 0, 0, 6'h0C);
    @(negedge clk);
    chk("rst_inst_req", {31'h0, inst_req}, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_retired", retired, 32'h0);
    release_reset();
    @(posedge clk);
    #1;
    chk("first_inst_req", {31'h0, inst_req}, 32'h1);
    chk("first_inst_addr", inst_addr, 32'h0);

    // ---------------- ALU program, zero-wait ----------------
    run_to_halt(200);
    chk("alu_halted", {31'h0, halted}, 32'h1);
    chk("alu_fault", {31'h0, fault}, 32'h0);
    chk("alu_retired", retired, 32'd4);
    chk("alu_r1", dut.rf[1], 32'd5);
    chk("alu_r2", dut.rf[2], 32'hFFFF_FFFD);
    chk("alu_r3", dut.rf[3], 32'd2);
    chk("alu_r4", dut.rf[4], 32'd1);
    chk("alu_nfetch", 32'(fetch_addr.size()), 32'd5);
    for (int k = 1; k < 5; k++)
      chk($sformatf("alu_spacing%0d", k), 32'(fetch_cyc[k] - fetch_cyc[k-1]), 32'd4);
    repeat (4) @(negedge clk);
    chk("alu_halt_sticky", {31'h0, halted}, 32'h1);
    chk("alu_halt_pc", inst_addr, 32'h10);
    chk("alu_halt_noreq", {31'h0, inst_req}, 32'h0);

    // ---------------- Load/store with 3 wait cycles ----------------
    start_reset();
    dmem[0] = 32'hDEAD_BEEF;
    imem[0] = enc_i(OP_LW, 0, 1, 16'd0);
    imem[1] = enc_i(OP_SW, 0, 1, 16'd8);
    imem[2] = enc_i(OP_LW, 0, 5, 16'd8);
    imem[3] = enc_r(0, 0, 0, 6'h0C);
    d_wait  = 3;
    release_reset();
    run_to_halt(300);
    chk("ls_halted", {31'h0, halted}, 32'h1);
    chk("ls_retired", retired, 32'd3);
    chk("ls_nacc", 32'(acc_addr.size()), 32'd3);
    chk("sw_addr", 32'(acc_addr[1]), 32'd8);
    chk("sw_we", 32'(acc_we[1]), 32'd1);
    chk("sw_wdata", 32'(acc_wd[1]), 32'hDEAD_BEEF);
    chk("sw_req_len", 32'(acc_len[1]), 32'd4);
    chk("sw_stable", 32'(acc_stable[1]), 32'd1);
    chk("lw_we", 32'(acc_we[2]), 32'd0);
    chk("ls_dmem2", dmem[2], 32'hDEAD_BEEF);
    chk("ls_r5", dut.rf[5], 32'hDEAD_BEEF);
    chk("lw_latency", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd8);
    chk("sw_latency", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd7);
    chk("lw2_latency", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd8);

    // ---------------- Branches, jump, R0 discard ----------------
    start_reset();
    imem[0]  = enc_i(OP_ADDI, 0, 1, 16'd7);
    imem[1]  = enc_i(OP_ADDI, 0, 0, 16'd9);
    imem[2]  = enc_r(0, 1, 6, 6'h25);
    imem[3]  = enc_r(0, 1, 8, 6'h22);
    imem[4]  = enc_i(OP_BEQ, 1, 0, 16'd2);
    imem[5]  = enc_i(OP_BEQ, 0, 0, 16'd2);
    imem[8]  = enc_j(26'h40);
    imem[64] = enc_r(0, 0, 0, 6'h0C);
    release_reset();
    run_to_halt(300);
    chk("br_halted", {31'h0, halted}, 32'h1);
    chk("br_retired", retired, 32'd7);
    chk("br_r6_or_r0", dut.rf[6], 32'd7);
    chk("br_r8_sub", dut.rf[8], 32'hFFFF_FFF9);
    chk("br_nfetch", 32'(fetch_addr.size()), 32'd8);
    chk("beq_not_taken", 32'(fetch_addr[5]), 32'h14);
    chk("beq_taken", 32'(fetch_addr[6]), 32'h20);
    chk("j_target", 32'(fetch_addr[7]), 32'h100);
    chk("beq_latency", 32'(fetch_cyc[5] - fetch_cyc[4]), 32'd3);
    chk("j_latency", 32'(fetch_cyc[7] - fetch_cyc[6]), 32'd3);

    start_reset();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd1);
    imem[1] = enc_i(OP_ADDI, 1, 1, 16'd1);
    imem[2] = enc_i(OP_ADDI, 1, 1, 16'd1);
    imem[3] = enc_i(OP_ADDI, 1, 1, 16'd1);
    imem[4] = enc_i(OP_BEQ, 0, 0, 16'hFFFF);
    release_reset();
    for (int n = 0; n < 200 && fetch_addr.size() < 8; n++) @(negedge clk);
    chk("loop_nfetch_ge8", 32'(fetch_addr.size() >= 8), 32'd1);
    chk("loop_self1", 32'(fetch_addr[5]), 32'h10);
    chk("loop_self2", 32'(fetch_addr[6]), 32'h10);
    chk("loop_r1", dut.rf[1], 32'd4);
    chk("loop_not_halted", {31'h0, halted}, 32'h0);

    // ---------------- Faults ----------------
    start_reset();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd3);
    imem[1] = 32'hFC00_0000;
    release_reset();
    run_to_halt(200);
    repeat (3) @(negedge clk);
    chk("ill_halted", {31'h0, halted}, 32'h1);
    chk("ill_fault", {31'h0, fault}, 32'h1);
    chk("ill_retired", retired, 32'd1);
    chk("ill_no_mem_req", {31'h0, mem_req_seen}, 32'h0);
    chk("ill_pc", inst_addr, 32'h4);
    chk("ill_r1", dut.rf[1], 32'd3);

    start_reset();
    imem[0] = enc_r(1, 2, 3, 6'h21);
    release_reset();
    run_to_halt(200);
    chk("ill_funct_halted", {31'h0, halted}, 32'h1);
    chk("ill_funct_fault", {31'h0, fault}, 32'h1);
    chk("ill_funct_retired", retired, 32'd0);

    start_reset();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd2);
    imem[1] = enc_i(OP_LW, 1, 5, 16'd4);
    release_reset();
    run_to_halt(200);
    repeat (3) @(negedge clk);
    chk("mis_halted", {31'h0, halted}, 32'h1);
    chk("mis_fault", {31'h0, fault}, 32'h1);
    chk("mis_retired", retired, 32'd1);
    chk("mis_no_mem_req", {31'h0, mem_req_seen}, 32'h0);
    chk("mis_pc", inst_addr, 32'h4);
    chk("mis_r5", dut.rf[5], 32'h0);

    // ---------------- Reset during a wait-stated load ----------------
    start_reset();
    dmem[3] = 32'h1234_5678;
    imem[0] = enc_i(OP_LW, 0, 7, 16'd12);
    d_wait  = 10;
    release_reset();
    for (int n = 0; n < 50 && !mem_req; n++) @(negedge clk);
    chk("mid_req_up", {31'h0, mem_req}, 32'h1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_req_drop", {31'h0, mem_req}, 32'h0);
    chk("mid_inst_req", {31'h0, inst_req}, 32'h0);
    imem[0] = enc_r(0, 0, 0, 6'h0C);
    force_dack = 1'b1;
    release_reset();
    repeat (3) @(negedge clk);
    force_dack = 1'b0;
    run_to_halt(200);
    chk("mid_restart_pc", 32'(fetch_addr[0]), 32'h0);
    chk("mid_r7", dut.rf[7], 32'h0);
    chk("mid_retired", retired, 32'd0);
    chk("mid_halted", {31'h0, halted}, 32'h1);
    chk("mid_fault", {31'h0, fault}, 32'h0);
    chk("mid_no_access", 32'(acc_addr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle successor to the single-cycle MIPS core. It executes a MIPS-I integer subset through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are reached over separate req/ack ports, so memory latency is variable. The register file and retired-instruction counter are internal, and the block sits at the top of the CPU, between the instruction memory and the data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NUM_REGS, 32, register count (power of 2, max 32); rs/rt/rd indices are truncated to log2(NUM_REGS) bits
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
inst_req  out  1  instruction fetch request
inst_addr  out  32  fetch address (PC)
inst_ack  in  1  fetch complete; inst is valid in the same cycle
inst  in  32  instruction word
mem_req  out  1  data access request
mem_we  out  1  1 = store, 0 = load; valid while mem_req=1
mem_addr  out  32  word address (ALU result)
mem_wdata  out  32  store data (rt)
mem_ack  in  1  access complete; mem_rdata is valid in the same cycle on loads
mem_rdata  in  32  load data
halted  out  1  core stopped
fault  out  1  stop cause was an illegal instruction or a misaligned access
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC, all registers=0.
  - inst_req, mem_req, mem_we, halted, fault = 0; retired = 0; inst_addr=RESET_PC; mem_addr, mem_wdata = 0.
  - Reset asserted mid-access drops both reqs immediately. A late ack arriving afterwards is ignored.
- Requests are registered:
  - A req rises on entry to its state and holds with stable addr/wdata/we until the cycle the ack is sampled high.
  - The req drops the next cycle. Ack back-to-back with req (zero wait) is legal.
  - An ack while req=0 is ignored.
- FETCH: inst_req=1, inst_addr=pc. On inst_ack, latch IR=inst → DECODE.
- DECODE:
  - A=R[rs], B=R[rt], imm=sign-extend(IR[15:0]), pc4=pc+4.
  - Branch target = pc4 + (imm<<2), mod 2^32.
  - Illegal opcode/funct → HALT with fault=1.
  - syscall (op 0, funct 0x0C) → HALT with fault=0.
  - Otherwise → EXEC.
- EXEC:
  - R-type, op 0: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). add/sub wrap with no overflow trap. → WB.
  - addi 0x08: A+imm → WB.
  - lw 0x23 / sw 0x2B: addr=A+imm. If addr[1:0]≠0 → HALT, fault=1. Otherwise → MEM.
  - beq 0x04: pc = (A==B) ? target : pc4 → FETCH, retire.
  - j 0x02: pc = {pc4[31:28], IR[25:0], 2'b00} → FETCH, retire.
- MEM: mem_req=1, mem_we=1 for sw. On mem_ack: sw → FETCH, pc=pc4, retire; lw latches MDR=mem_rdata → WB.
- WB:
  - Write rd (R-type) or rt (addi/lw); writes to register 0 are discarded and R0 always reads 0.
  - pc=pc4, retire → FETCH.
- Retire: retired increments by 1 and wraps at 2^CNT_W. syscall and faulting instructions do not retire.
- HALT:
  - halted=1, sticky until reset. No further reqs; pc holds at the halting instruction's address.
  - Register contents are frozen, and fault holds its value.
- Latency with zero-wait memory, in cycles from FETCH entry to next FETCH entry: R-type/addi 4, lw 5, sw 4, beq/j 3.
- Each wait cycle on an ack adds one cycle. Latency has no upper bound and no timeout.

Test Plan:
- Reset: hold rst, release → inst_req=1 and inst_addr=0 next edge. All other outputs match the reset values above: halted=0, fault=0, retired=0.
- ALU, zero-wait memory:
  - Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; syscall.
  - Required: R3=2, R4=1, halted=1, fault=0, retired=4.
  - Fetch-to-fetch spacing is 4 cycles per instruction.
- Load/store with waits:
  - sw $1,8($0) with R1=0xDEADBEEF, then lw $5,8($0), with mem_ack delayed 3 cycles.
  - Required: mem_addr=8, mem_we=1 and mem_wdata=0xDEADBEEF held stable for 4 cycles; R5=0xDEADBEEF; lw takes 8 cycles.
- Branch/jump:
  - beq $0,$0,-1 at pc=0x10 → next inst_addr=0x10.
  - beq $1,$0,+2 with R1≠0 → 0x14.
  - j 0x40 at pc=0x20 → inst_addr=0x100.
- Faults:
  - Opcode 0x3F → halted=1, fault=1, retired unchanged, no mem_req.
  - lw with addr=0x6 → halted=1, fault=1, and mem_req never asserts.
- Reset mid-operation: assert rst while mem_req=1 on a wait-stated lw → mem_req=0 immediately. After release, fetch restarts at RESET_PC and the destination register reads 0.
